uart_tx: RTL
============

# uart_tx

Serial UART transmitter for the APB UART peripheral; the transmit-side counterpart of the block's receiver. It takes bytes from the TX FIFO over a valid/ready handshake and serialises them on `tx_o` as start bit, 5–8 LSB-first data bits, optional parity, and 1 or 2 stop bits. All frame parameters come from the same configuration registers that drive the receiver, so a frame produced here decodes cleanly under identical settings.

## Interface
Parameters: none.

Ports:
- `clk_i` input 1: clock. One clock domain; everything is sampled on the rising edge.
- `rstn_i` input 1: reset. Synchronous, active-low.
- `tx_o` output 1: serial line, registered. Idle level is 1.
- `busy_o` output 1: high whenever state ≠ IDLE.
- `cfg_div_i` input 16: bit period minus one, in clock cycles.
- `cfg_en_i` input 1: block enable.
- `cfg_parity_en_i` input 1: insert a parity bit.
- `cfg_parity_sel_i` input 2: parity bit value.
  - 00: ~^data
  - 01: ^data
  - 10: constant 0
  - 11: constant 1
- `cfg_bits_i` input 2: data bits. 00=5, 01=6, 10=7, 11=8.
- `cfg_stop_bits_i` input 1: 0 = one stop bit, 1 = two stop bits.
- `tx_data_i` input 8: byte to send. Only the low N bits are used.
- `tx_valid_i` input 1: `tx_data_i` is valid.
- `tx_ready_o` output 1: combinational, `(state==IDLE) & cfg_en_i`.

## Operation
- States: IDLE, START_BIT, DATA, PARITY, STOP_BIT.
- Transfer handshake: a transfer occurs when `tx_valid_i & tx_ready_o`. In that cycle the block latches:
  - the data into an 8-bit shift register;
  - `cfg_div_i`, `cfg_bits_i`, `cfg_parity_en_i`, `cfg_parity_sel_i` and `cfg_stop_bits_i` into frame registers.
  - Configuration changes mid-frame have no effect on the current frame.
- State transitions:
  - IDLE → START_BIT on a transfer.
  - START_BIT → DATA after one bit period.
  - DATA stays put until N bits have been sent, then → PARITY if parity is enabled, else → STOP_BIT.
  - PARITY → STOP_BIT after one bit period.
  - STOP_BIT → IDLE after 1 or 2 bit periods.
- Line level per state:
  - IDLE: `tx_o`=1.
  - START_BIT: `tx_o`=0.
  - DATA: `tx_o` = shift register bit 0; the register shifts right at each bit end.
  - STOP_BIT: `tx_o`=1.
- Parity: computed as XOR over the latched low N bits, accumulated during DATA. The selection is applied per `cfg_parity_sel_i`.
- Bit counter: 3 bits. It reaches N−1 on the last data bit and is cleared on leaving DATA.
- Baud counter: 16 bits. It counts 0..`div` and cleared on every state entry. A bit ends on the cycle when counter == `div`, so each bit lasts `div`+1 cycles. `div`=0 is legal and gives 1 cycle per bit.
- Disable: `cfg_en_i`=0 forces state IDLE on the next edge.
  - Counters clear and `tx_o` returns to 1 on the next edge.
  - An in-flight frame is aborted and is never resumed.
- Reset (`rstn_i`=0 at an edge) gives state IDLE, `tx_o`=1, `busy_o`=0, all counters and the shift register 0. Reset mid-frame aborts the frame the same way. `tx_ready_o` = `cfg_en_i` after reset.

## Timing
- Transfer at edge T gives `tx_o`=0 starting at T+1.
- Data bit k occupies cycles T+1+(k+1)(`div`+1) onward, each lasting `div`+1 cycles.
- Frame length L = (1+N+P+S)(`div`+1) cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- `busy_o` is high for cycles T+1 … T+L.
- `tx_ready_o` is low for cycles T+1 … T+L and high at T+L+1.
- Back-to-back frames: the next transfer at the earliest occurs at T+L+1. This guarantees one extra idle-high cycle between frames.
- `tx_valid_i` asserted while `tx_ready_o`=0 is ignored; the source must hold it.

## Test plan
- Reset then `cfg_en_i`=1: check `tx_o`=1, `busy_o`=0, `tx_ready_o`=1.
  - Send 0xA5 with 8N1 (`div`=3).
  - Required `tx_o`: 0, 1,0,1,0,0,1,0,1, 1, with 4 cycles per bit. The total is 40 cycles and `tx_ready_o` rises at T+41.
- 5 bits, parity sel 00, 2 stop bits, `div`=0, data 0x1F (low 5 bits = 11111, ^=1).
  - Required line: 0, 1×5, parity 0, 1, 1. Total 9 cycles.
- Parity sel 01/10/11 with data 0x03 in 8-bit mode.
  - Required parity bit: 0 (sel 01), 0 (sel 10), 1 (sel 11).
- Hold `tx_valid_i`=1 with two bytes, 0x55 then 0x0F.
  - The second transfer must occur exactly one cycle after `busy_o` falls.
  - Decoding `tx_o` with a model receiver must yield both bytes.
- Disruption mid-frame (`div`=7):
  - Deassert `cfg_en_i` during DATA bit 3: `tx_o`=1 and state IDLE on the next edge.
  - Pull `rstn_i` low mid-stop-bit: the same result, with no residual frame once re-enabled.
  - Change `cfg_bits_i` mid-frame: the current frame length is unaffected.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per frame as start, 5-8 LSB-first data bits, optional parity, 1-2 stop bits.
// Latency: transfer at edge T drives the start bit from T+1; a frame occupies (1+N+P+S)*(div+1) cycles.
// Backpressure: tx_ready_o is low from the transfer until the frame has finished; tx_valid_i is held by the source meanwhile.
//
// Ports:
//   clk_i, rstn_i       clock, synchronous active-low reset
//   cfg_*_i             frame configuration (divider, enable, parity, data bits, stop bits), captured per frame
//   tx_data_i/valid/ready  byte input handshake
//   tx_o                registered serial line (idle high)
//   busy_o              high while a frame is on the line
module uart_tx (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        tx_o,
    output logic        busy_o,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_en_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_parity_sel_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o
);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PARITY,
        STOP_BIT
    } state_t;

    state_t      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic        stop_cnt_q;
    logic        tx_q;

    // Frame settings captured at the transfer so mid-frame config writes are harmless.
    logic [15:0] div_q;
    logic [1:0]  bits_q;
    logic        par_en_q;
    logic [1:0]  par_sel_q;
    logic        stop_q;

    logic        bit_end;
    logic        last_bit;
    logic        par_acc;
    logic        par_bit;

    assign bit_end  = (baud_q == div_q);
    // Bit index of the last data bit is N-1 = 4 + cfg_bits.
    assign last_bit = (bit_q == (3'd4 + {1'b0, bits_q}));
    // Parity including the bit currently on the line, needed at the DATA->PARITY edge.
    assign par_acc  = par_q ^ shift_q[0];

    always_comb begin
        par_bit = 1'b0;
        case (par_sel_q)
            2'b00:   par_bit = ~par_acc;
            2'b01:   par_bit = par_acc;
            2'b10:   par_bit = 1'b0;
            default: par_bit = 1'b1;
        endcase
    end

    // tx_q is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state and stays registered.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || !cfg_en_i) begin
            state_q    <= IDLE;
            baud_q     <= 16'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            if (!rstn_i) begin
                div_q     <= 16'd0;
                bits_q    <= 2'd0;
                par_en_q  <= 1'b0;
                par_sel_q <= 2'd0;
                stop_q    <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_valid_i) begin
                        state_q    <= START_BIT;
                        shift_q    <= tx_data_i;
                        div_q      <= cfg_div_i;
                        bits_q     <= cfg_bits_i;
                        par_en_q   <= cfg_parity_en_i;
                        par_sel_q  <= cfg_parity_sel_i;
                        stop_q     <= cfg_stop_bits_i;
                        baud_q     <= 16'd0;
                        bit_q      <= 3'd0;
                        par_q      <= 1'b0;
                        stop_cnt_q <= 1'b0;
                        tx_q       <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        baud_q  <= 16'd0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q  <= 16'd0;
                        par_q   <= par_acc;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (last_bit) begin
                            bit_q <= 3'd0;
                            if (par_en_q) begin
                                state_q <= PARITY;
                                tx_q    <= par_bit;
                            end else begin
                                state_q    <= STOP_BIT;
                                stop_cnt_q <= 1'b0;
                                tx_q       <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q    <= STOP_BIT;
                        baud_q     <= 16'd0;
                        stop_cnt_q <= 1'b0;
                        tx_q       <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP_BIT: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        baud_q <= 16'd0;
                        if (stop_cnt_q == stop_q) begin
                            state_q <= IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != IDLE);
    assign tx_ready_o = (state_q == IDLE) & cfg_en_i;

endmodule
